// File: rtl/sram_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sram_rr_arbiter_if                                          |
// | Purpose  : Bundles the two requester command/response channels and the |
// |            SRAM pin group that the arbiter sits between.               |
// | Ports    : req0/1, we0/1, addr0/1, wdata0/1   requester commands      |
// |            gnt0/1, done0/1, rdata, busy       requester responses     |
// |            read_write, address, data_in       arbiter -> SRAM         |
// |            data_out                           SRAM -> arbiter         |
// | Modports : slave  - arbiter side                                       |
// |            master - requesters + SRAM side (bench / surrounding logic) |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface sram_rr_arbiter_if #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 1
);
  // requester 0
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  // requester 1
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  // shared response / status
  logic [DATA_W-1:0] rdata;
  logic              busy;
  // SRAM pins
  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  data_out,
    output gnt0, done0, gnt1, done1,
    output rdata, busy,
    output read_write, address, data_in
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output data_out,
    input  gnt0, done0, gnt1, done1,
    input  rdata, busy,
    input  read_write, address, data_in
  );
endinterface
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sram_rr_arbiter                                             |
// | Purpose  : Two-requester round-robin arbiter/sequencer for a           |
// |            synchronous single-port SRAM. Takes one command at a time,  |
// |            drives the SRAM pins for one cycle, waits out the read      |
// |            latency and returns a one-cycle done pulse (+ read data).   |
// | Ports    : clk    - clock, all state changes on posedge               |
// |            rst_n  - synchronous active-low reset                      |
// |            bus    - sram_rr_arbiter_if.slave (requesters + SRAM pins) |
// | Params   : DATA_W (word width), ADDR_W (address width),               |
// |            RD_LAT (read latency in cycles, 1..4)                      |
// | Build    : define ARB_FIXED_PRIO_EN for fixed priority (requester 0   |
// |            always wins a tie); default is round-robin.                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module sram_rr_arbiter #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 1,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  sram_rr_arbiter_if.slave bus
);

  // Counter preload: WAIT lasts RD_LAT cycles, the last one with count 0.
  localparam logic [1:0] C_CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic              r_last,       w_last_nxt;
  logic              r_owner,      w_owner_nxt;
  logic [1:0]        r_cnt,        w_cnt_nxt;
  logic [DATA_W-1:0] r_rdata,      w_rdata_nxt;
  logic              r_read_write, w_read_write_nxt;
  logic [ADDR_W-1:0] r_address,    w_address_nxt;
  logic [DATA_W-1:0] r_data_in,    w_data_in_nxt;

  logic w_pick1;
  logic w_gnt0, w_gnt1;
  logic w_done0, w_done1;

  // Tie-break choice for requester 1; only meaningful when req1 is high.
`ifdef ARB_FIXED_PRIO_EN
  assign w_pick1 = bus.req1 & ~bus.req0;
`else
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= 2'd0;
      r_rdata      <= '0;
      r_read_write <= 1'b0;
      r_address    <= '0;
      r_data_in    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rdata      <= w_rdata_nxt;
      r_read_write <= w_read_write_nxt;
      r_address    <= w_address_nxt;
      r_data_in    <= w_data_in_nxt;
    end
  end

  // The SRAM pin registers double as the command latch: they are loaded on
  // grant, so they present the command during ISSUE, and read_write still
  // holds the command's we while in ISSUE.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_owner_nxt      = r_owner;
    w_cnt_nxt        = r_cnt;
    w_rdata_nxt      = r_rdata;
    w_read_write_nxt = 1'b0;
    w_address_nxt    = r_address;
    w_data_in_nxt    = r_data_in;
    w_gnt0           = 1'b0;
    w_gnt1           = 1'b0;
    w_done0          = 1'b0;
    w_done1          = 1'b0;

    case (r_state)
      IDLE: begin
        // Grants are suppressed while reset is asserted so nothing is
        // accepted that the reset edge would then discard.
        if (rst_n) begin
          w_gnt1 = w_pick1;
          w_gnt0 = bus.req0 & ~w_pick1;
          if (w_gnt0 || w_gnt1) begin
            w_owner_nxt      = w_gnt1;
            w_read_write_nxt = w_gnt1 ? bus.we1   : bus.we0;
            w_address_nxt    = w_gnt1 ? bus.addr1 : bus.addr0;
            w_data_in_nxt    = w_gnt1 ? bus.wdata1 : bus.wdata0;
            w_state_nxt      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_read_write) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = C_CNT_INIT;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_rdata_nxt = bus.data_out;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      DONE: begin
        // A reset arriving in DONE abandons the command: no pulse.
        w_done0     = rst_n & ~r_owner;
        w_done1     = rst_n &  r_owner;
        w_last_nxt  = r_owner;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.done0      = w_done0;
  assign bus.done1      = w_done1;
  assign bus.rdata      = r_rdata;
  assign bus.busy       = (r_state != IDLE);
  assign bus.read_write = r_read_write;
  assign bus.address    = r_address;
  assign bus.data_in    = r_data_in;

endmodule
`default_nettype wire
